// File: rtl/cia_sdr_shift.sv
// cia_sdr_shift: serial shift engine behind the CIA SDR register.
//   Output mode (spmode=1): serialises written bytes on SP, clocked on CNT by
//   timer A underflows; a write during a transfer is held as a pending byte.
//   Input mode (spmode=0): assembles bytes from an external CNT/SP stream.
// Ports:
//   E_CLK, RESET_n        clock, async active-low reset
//   spmode                1 = transmit, 0 = receive
//   ta_underflow          timer A underflow pulse
//   wr_sdr, wr_data       CPU write strobe and data for SDR
//   sdr_q                 SDR read value
//   cnt_in, sp_in         CNT/SP pin inputs
//   cnt_out/cnt_oe        CNT pin drive value / enable
//   sp_out/sp_oe          SP pin drive value / enable
//   sp_irq                one-cycle pulse per completed byte
//   busy                  output-mode transfer in progress
// Build option: define SDR_SYNC_EN to add a 2-flop synchroniser on CNT/SP.
module cia_sdr_shift (
  input  logic       E_CLK,
  input  logic       RESET_n,
  input  logic       spmode,
  input  logic       ta_underflow,
  input  logic       wr_sdr,
  input  logic [7:0] wr_data,
  output logic [7:0] sdr_q,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic       cnt_out,
  output logic       cnt_oe,
  output logic       sp_out,
  output logic       sp_oe,
  output logic       sp_irq,
  output logic       busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned HW = 4;  // half-bit counter: 16 underflows per byte
  localparam int unsigned BW = 3;  // input bit counter: 8 edges per byte

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [HW-1:0] half_q, half_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] sdr_d;
  logic          cnt_out_d, sp_out_d, sp_irq_d, busy_d;
  logic          cnt_r_q, cnt_prev_q, sp_r_q;
  logic          cnt_smp, sp_smp;
  logic          mode_chg, rise;

`ifdef SDR_SYNC_EN
  logic [1:0] cnt_sync_q, sp_sync_q;

  // Two-flop synchroniser for asynchronous CNT/SP pins (idle high).
  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_sync_q <= 2'b11;
      sp_sync_q  <= 2'b11;
    end else begin
      cnt_sync_q <= {cnt_sync_q[0], cnt_in};
      sp_sync_q  <= {sp_sync_q[0], sp_in};
    end
  end

  assign cnt_smp = cnt_sync_q[1];
  assign sp_smp  = sp_sync_q[1];
`else
  assign cnt_smp = cnt_in;
  assign sp_smp  = sp_in;
`endif

  // cnt_oe holds last cycle's spmode, so a difference marks a mode change.
  assign mode_chg = (spmode != cnt_oe);
  assign rise     = cnt_r_q & ~cnt_prev_q;

  // State and datapath registers. CNT registers reset high so release is not an edge.
  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      half_q     <= '0;
      bit_q      <= '0;
      sdr_q      <= '0;
      cnt_out    <= 1'b1;
      sp_out     <= 1'b1;
      cnt_oe     <= 1'b0;
      sp_oe      <= 1'b0;
      sp_irq     <= 1'b0;
      busy       <= 1'b0;
      cnt_r_q    <= 1'b1;
      cnt_prev_q <= 1'b1;
      sp_r_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      sdr_q      <= sdr_d;
      cnt_out    <= cnt_out_d;
      sp_out     <= sp_out_d;
      cnt_oe     <= spmode;
      sp_oe      <= spmode;
      sp_irq     <= sp_irq_d;
      busy       <= busy_d;
      cnt_r_q    <= cnt_smp;
      cnt_prev_q <= cnt_r_q;
      sp_r_q     <= sp_smp;
    end
  end

  // Next state: transmit FSM only runs in output mode with a stable mode bit.
  always_comb begin
    state_d = state_q;
    if (mode_chg || !spmode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (wr_sdr) state_d = ST_SHIFT;
        ST_SHIFT: if (ta_underflow && (half_q == HW'(15)) && !pend_vld_q && !wr_sdr)
                    state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    sh_d       = sh_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    half_d     = half_q;
    bit_d      = bit_q;
    sdr_d      = sdr_q;
    cnt_out_d  = cnt_out;
    sp_out_d   = sp_out;
    sp_irq_d   = 1'b0;
    busy_d     = busy;

    if (mode_chg) begin
      // Abort any byte in flight; SDR contents survive.
      half_d     = '0;
      bit_d      = '0;
      pend_vld_d = 1'b0;
      busy_d     = 1'b0;
      cnt_out_d  = 1'b1;
      if (wr_sdr) sdr_d = wr_data;
    end else if (spmode) begin
      case (state_q)
        ST_IDLE: begin
          if (wr_sdr) begin
            sdr_d  = wr_data;
            sh_d   = wr_data;
            busy_d = 1'b1;
            half_d = '0;
          end
        end
        ST_SHIFT: begin
          if (wr_sdr) begin
            sdr_d      = wr_data;
            pend_d     = wr_data;
            pend_vld_d = 1'b1;
          end
          if (ta_underflow) begin
            cnt_out_d = ~cnt_out;
            half_d    = half_q + HW'(1);
            // Data changes on the falling CNT toggle; receiver samples on the rising one.
            if (cnt_out) begin
              sp_out_d = sh_q[DW-1];
              sh_d     = {sh_q[DW-2:0], 1'b0};
            end
            if (half_q == HW'(15)) begin
              sp_irq_d = 1'b1;
              if (pend_vld_q) begin
                // Older pending byte goes first; a same-cycle write becomes the new pending.
                sh_d       = pend_q;
                pend_vld_d = wr_sdr;
              end else if (wr_sdr) begin
                sh_d       = wr_data;
                pend_vld_d = 1'b0;
              end else begin
                busy_d    = 1'b0;
                cnt_out_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end else begin
      busy_d = 1'b0;
      if (wr_sdr) sdr_d = wr_data;
      if (rise) begin
        sh_d  = {sh_q[DW-2:0], sp_r_q};
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(7)) begin
          // Received byte overrides a coincident CPU write.
          sdr_d    = {sh_q[DW-2:0], sp_r_q};
          sp_irq_d = 1'b1;
          bit_d    = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cia_sdr_shift.sv
// Randomised self-checking bench for cia_sdr_shift. Expected serial bits are
// derived from byte values by shifting; IRQ pulses are counted per byte.
module tb_cia_sdr_shift;

  logic       E_CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       spmode = 1'b0;
  logic       ta_underflow = 1'b0;
  logic       wr_sdr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] sdr_q;
  logic       cnt_in = 1'b1;
  logic       sp_in = 1'b1;
  logic       cnt_out, cnt_oe, sp_out, sp_oe, sp_irq, busy;

  int checks = 0;
  int failures = 0;
  int irq_cnt = 0;

`ifdef SDR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  cia_sdr_shift dut (
    .E_CLK(E_CLK), .RESET_n(RESET_n), .spmode(spmode),
    .ta_underflow(ta_underflow), .wr_sdr(wr_sdr), .wr_data(wr_data),
    .sdr_q(sdr_q), .cnt_in(cnt_in), .sp_in(sp_in),
    .cnt_out(cnt_out), .cnt_oe(cnt_oe), .sp_out(sp_out), .sp_oe(sp_oe),
    .sp_irq(sp_irq), .busy(busy)
  );

  always #5 E_CLK = ~E_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge E_CLK);
    #1;
    if (sp_irq === 1'b1) irq_cnt++;
  endtask

  // Transmit one byte (or two back-to-back, second written after 3 underflows).
  task automatic tx_test(input logic [7:0] b0, input bit second, input logic [7:0] b1,
                         input int gmin, input int gmax);
    int nu;
    int irq0;
    logic [15:0] stream;
    nu = second ? 32 : 16;
    stream = {b0, b1};
    wr_sdr = 1'b1;
    wr_data = b0;
    ta_underflow = 1'($urandom_range(0, 1));  // coincident underflow must not count
    step();
    wr_sdr = 1'b0;
    ta_underflow = 1'b0;
    check("tx_busy_start", busy, 1);
    check("tx_sdr_written", sdr_q, b0);
    irq0 = irq_cnt;
    for (int u = 1; u <= nu; u++) begin
      if (second && u == 4) begin
        wr_sdr = 1'b1;
        wr_data = b1;
        step();
        wr_sdr = 1'b0;
        check("tx_busy_pend", busy, 1);
      end
      repeat ($urandom_range(gmin, gmax)) step();
      ta_underflow = 1'b1;
      step();
      ta_underflow = 1'b0;
      check("tx_cnt", cnt_out, (u % 2 == 0) ? 1 : 0);
      if (u % 2 == 1) check("tx_sp_bit", sp_out, stream[15 - (u - 1) / 2]);
      if (u % 16 == 0) begin
        check("tx_irq", sp_irq, 1);
        check("tx_busy_end", busy, (u < nu) ? 1 : 0);
      end
    end
    step();
    check("tx_irq_count", irq_cnt - irq0, nu / 16);
    check("tx_sdr_final", sdr_q, second ? b1 : b0);
    check("tx_idle_cnt", cnt_out, 1);
    check("tx_idle_busy", busy, 0);
  endtask

  // Feed one byte MSB first on SP with an 8-cycle CNT period.
  task automatic rx_byte(input logic [7:0] b, input bit collide, input logic [7:0] wv);
    int irq0;
    irq0 = irq_cnt;
    for (int i = 0; i < 8; i++) begin
      cnt_in = 1'b0;
      sp_in = b[7 - i];
      repeat (4) step();
      cnt_in = 1'b1;
      if (i < 7) begin
        repeat (4) step();
      end else begin
        repeat (LAT - 1) step();
        if (collide) begin
          wr_sdr = 1'b1;
          wr_data = wv;
        end
        step();
        wr_sdr = 1'b0;
        check("rx_irq", sp_irq, 1);
        check("rx_data", sdr_q, b);
        repeat (4) step();
      end
    end
    check("rx_irq_count", irq_cnt - irq0, 1);
    check("rx_busy", busy, 0);
    check("rx_oe", {cnt_oe, sp_oe}, 0);
  endtask

  initial begin
    logic [7:0] rb;
    int irq0;

    // Reset state
    repeat (3) @(posedge E_CLK);
    #1;
    check("rst_sdr", sdr_q, 8'h00);
    check("rst_cnt_out", cnt_out, 1);
    check("rst_sp_out", sp_out, 1);
    check("rst_oe", {cnt_oe, sp_oe}, 0);
    check("rst_irq", sp_irq, 0);
    check("rst_busy", busy, 0);
    @(negedge E_CLK);
    RESET_n = 1'b1;
    repeat (2) step();

    // Reset in the middle of a transmission
    spmode = 1'b1;
    repeat (2) step();
    wr_sdr = 1'b1;
    wr_data = 8'h77;
    step();
    wr_sdr = 1'b0;
    for (int u = 0; u < 5; u++) begin
      step();
      ta_underflow = 1'b1;
      step();
      ta_underflow = 1'b0;
    end
    check("midrst_busy_before", busy, 1);
    #2;
    RESET_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sdr", sdr_q, 8'h00);
    check("midrst_cnt", cnt_out, 1);
    check("midrst_sp", sp_out, 1);
    check("midrst_oe", {cnt_oe, sp_oe}, 0);
    check("midrst_irq", sp_irq, 0);
    @(negedge E_CLK);
    RESET_n = 1'b1;
    step();
    check("postrst_busy", busy, 0);
    check("postrst_sdr", sdr_q, 8'h00);
    repeat (2) step();
    check("tx_oe", {cnt_oe, sp_oe}, 2'b11);

    // Output mode: directed then random bytes
    tx_test(8'hA5, 1'b0, 8'h00, 3, 3);
    tx_test(8'h3C, 1'b1, 8'hC3, 3, 3);
    for (int n = 0; n < 6; n++) begin
      tx_test(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 0, 4);
      repeat ($urandom_range(0, 3)) step();
    end

    // Mode change 1->0 mid-byte aborts without an interrupt
    rb = 8'($urandom);
    wr_sdr = 1'b1;
    wr_data = rb;
    step();
    wr_sdr = 1'b0;
    irq0 = irq_cnt;
    for (int u = 0; u < 7; u++) begin
      step();
      ta_underflow = 1'b1;
      step();
      ta_underflow = 1'b0;
    end
    spmode = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_oe", {cnt_oe, sp_oe}, 0);
    check("abort_cnt", cnt_out, 1);
    check("abort_sdr", sdr_q, rb);
    // Underflows in input mode must not toggle CNT
    for (int u = 0; u < 3; u++) begin
      ta_underflow = 1'b1;
      step();
      ta_underflow = 1'b0;
      step();
    end
    check("abort_cnt_idle", cnt_out, 1);
    check("abort_no_irq", irq_cnt - irq0, 0);

    // Input mode
    rx_byte(8'h5A, 1'b0, 8'h00);
    rx_byte(8'hFF, 1'b0, 8'h00);
    for (int n = 0; n < 4; n++) rx_byte(8'($urandom), 1'b0, 8'h00);
    rx_byte(8'h99, 1'b1, 8'h11);
    wr_sdr = 1'b1;
    wr_data = 8'h42;
    step();
    wr_sdr = 1'b0;
    check("rx_wr_sdr", sdr_q, 8'h42);
    repeat (3) step();
    check("rx_wr_no_busy", busy, 0);
    check("rx_wr_cnt", cnt_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
